// File: rtl/c25x_pll_pkg.sv
// Shared types and default timing for the c25x PLL phase controller.
// State encoding, PHASESEL output encodings and a constant max helper for timer sizing.
package c25x_pll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_SETTLE,
    ST_LOAD,
    ST_PRST,
    ST_WAIT_LOCK
  } pll_state_e;

  localparam logic [1:0] SEL_CLKOP  = 2'd0;
  localparam logic [1:0] SEL_CLKOS  = 2'd1;
  localparam logic [1:0] SEL_CLKOS2 = 2'd2;
  localparam logic [1:0] SEL_CLKOS3 = 2'd3;

  localparam int unsigned DEF_SETUP_CYC  = 2;
  localparam int unsigned DEF_STEP_W     = 4;
  localparam int unsigned DEF_GAP_W      = 4;
  localparam int unsigned DEF_SETTLE_CYC = 16;
  localparam int unsigned DEF_RST_W      = 8;
  localparam int unsigned DEF_LOCK_TO    = 4096;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/c25x_pll_phase_ctrl.sv
// Sequences EHXPLLL dynamic phase steps (SEL/DIR setup, STEP pulses, LOADREG) and supervises lock.
// Accepts one move per req/ack handshake; on lock loss aborts, pulses PLL reset, and waits for relock.
module c25x_pll_phase_ctrl
  import c25x_pll_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned STEP_W     = DEF_STEP_W,
  parameter int unsigned GAP_W      = DEF_GAP_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned RST_W      = DEF_RST_W,
  parameter int unsigned LOCK_TO    = DEF_LOCK_TO
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic [1:0] i_sel,
  input  logic       i_dir,
  input  logic [7:0] i_steps,
  output logic       o_ack,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_phasesel,
  output logic       o_phasedir,
  output logic       o_phasestep,
  output logic       o_phaseloadreg,
  input  logic       i_pll_lock,
  output logic       o_pll_rst
);

  localparam int unsigned MAX_PAR = max_u(max_u(max_u(SETUP_CYC, STEP_W), max_u(GAP_W, SETTLE_CYC)),
                                          max_u(RST_W, LOCK_TO));
  localparam int unsigned TMR_W   = $clog2(MAX_PAR) + 1;

  localparam logic [TMR_W-1:0] SETUP_LAST  = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] STEP_LAST   = TMR_W'(STEP_W - 1);
  localparam logic [TMR_W-1:0] GAP_LAST    = TMR_W'(GAP_W - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_W - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TO - 1);

  pll_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       steps_q, steps_d;
  logic [1:0]       sel_q, sel_d;
  logic             dir_q, dir_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             step_q, step_d;
  logic             load_q, load_d;
  logic             prst_q, prst_d;
  logic             lock_lost;

  // Lock supervision only applies once the PLL has been declared locked.
  assign lock_lost = !i_pll_lock && (state_q != ST_PRST) && (state_q != ST_WAIT_LOCK);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TMR_W'(1);
    steps_d = steps_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    load_d  = 1'b0;
    busy_d  = done_q ? 1'b0 : busy_q;
    err_d   = err_q;

    if (lock_lost) begin
      state_d = ST_PRST;
      busy_d  = 1'b1;
      if (state_q != ST_IDLE) err_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_req) begin
            sel_d   = i_sel;
            dir_d   = i_dir;
            steps_d = i_steps;
            ack_d   = 1'b1;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            state_d = ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_q == SETUP_LAST) state_d = (steps_q != 8'd0) ? ST_STEP_HI : ST_LOAD;
        end
        ST_STEP_HI: begin
          if (tmr_q == STEP_LAST) begin
            state_d = ST_STEP_LO;
            steps_d = (steps_q != 8'd0) ? steps_q - 8'd1 : 8'd0;
          end
        end
        ST_STEP_LO: begin
          if (tmr_q == GAP_LAST) state_d = (steps_q != 8'd0) ? ST_STEP_HI : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (tmr_q == SETTLE_LAST) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          load_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_PRST: begin
          if (tmr_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (i_pll_lock) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else if (tmr_q == LOCK_LAST) begin
            err_d   = 1'b1;
            state_d = ST_PRST;
          end
        end
        default: state_d = ST_WAIT_LOCK;
      endcase
    end

    // Elapsed-cycle timer: restarts on every state change and rests in IDLE.
    if ((state_d != state_q) || (state_q == ST_IDLE)) tmr_d = '0;

    step_d = (state_d == ST_STEP_HI);
    prst_d = (state_d == ST_PRST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_WAIT_LOCK;
      tmr_q   <= '0;
      steps_q <= '0;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      step_q  <= 1'b0;
      load_q  <= 1'b0;
      prst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      steps_q <= steps_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      step_q  <= step_d;
      load_q  <= load_d;
      prst_q  <= prst_d;
    end
  end

  assign o_ack          = ack_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_phasesel     = sel_q;
  assign o_phasedir     = dir_q;
  assign o_phasestep    = step_q;
  assign o_phaseloadreg = load_q;
  assign o_pll_rst      = prst_q;

endmodule

// File: tb/tb_c25x_pll_phase_ctrl.sv
// Directed bench for c25x_pll_phase_ctrl with default timing; expected cycles hand-derived.
module tb_c25x_pll_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst, req, dir, lock;
  logic [1:0] sel;
  logic [7:0] steps;
  logic       ack, busy, done, err, phasedir, phasestep, loadreg, pll_rst;
  logic [1:0] phasesel;

  int checks = 0;
  int errors = 0;

  logic [63:0] ps_vec, busy_vec;
  int done_cyc, load_cyc, ack_cyc, done_cnt;

  always #5 clk = ~clk;

  c25x_pll_phase_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_sel(sel), .i_dir(dir), .i_steps(steps),
    .o_ack(ack), .o_busy(busy), .o_done(done), .o_err(err),
    .o_phasesel(phasesel), .o_phasedir(phasedir), .o_phasestep(phasestep),
    .o_phaseloadreg(loadreg), .i_pll_lock(lock), .o_pll_rst(pll_rst)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected PHASESTEP trace for n pulses: first rise 2 cycles after ack, 4 high / 4 low.
  function automatic logic [63:0] exp_ps(input int n);
    logic [63:0] v;
    v = '0;
    for (int c = 2; c < 64; c++)
      if (c < 2 + 8 * n && ((c - 2) % 8) < 4) v[c] = 1'b1;
    return v;
  endfunction

  task automatic capture(input int ncyc);
    ps_vec = '0; busy_vec = '0;
    done_cyc = -1; load_cyc = -1; ack_cyc = -1; done_cnt = 0;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      ps_vec[c]   = phasestep;
      busy_vec[c] = busy;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (loadreg && load_cyc < 0) load_cyc = c;
      if (ack) begin
        if (ack_cyc < 0) ack_cyc = c;
        req = 1'b0;
      end
    end
  endtask

  task automatic issue(input logic [1:0] s, input logic d, input logic [7:0] n, output bit got);
    req = 1'b1; sel = s; dir = d; steps = n; got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      tick();
      if (ack) got = 1'b1;
    end
    req = 1'b0;
  endtask

  initial begin
    bit got;
    int hi, lo, acks;
    logic err_before;

    rst = 1'b1; req = 1'b0; sel = '0; dir = 1'b0; steps = '0; lock = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 1);
    chk("rst_outs", {ack, done, err, phasestep, loadreg, pll_rst}, 0);
    chk("rst_sel", {phasesel, phasedir}, 0);
    lock = 1'b1;
    tick();
    chk("lock_busy_fall", busy, 0);

    // Three-step move on CLKOS2, lag direction.
    issue(SEL2(), 1'b0, 8'd3, got);
    chk("t2_ack", got, 1);
    chk("t2_sel", {phasesel, phasedir}, {2'd2, 1'b0});
    chk("t2_busy", busy, 1);
    capture(46);
    chk("t2_step_trace", ps_vec, exp_ps(3));
    chk("t2_done_cyc", done_cyc, 43);
    chk("t2_load_cyc", load_cyc, 43);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_busy_43_44", {busy_vec[43], busy_vec[44]}, 2'b10);
    chk("t2_sel_hold", phasesel, 2);

    // Zero-step move: no pulses, load+done three cycles after ack.
    issue(2'd3, 1'b1, 8'd0, got);
    chk("t3_ack", got, 1);
    capture(8);
    chk("t3_no_step", ps_vec, 0);
    chk("t3_done_cyc", done_cyc, 3);
    chk("t3_load_cyc", load_cyc, 3);
    chk("t3_sel", {phasesel, phasedir}, {2'd3, 1'b1});

    // Lock lost during the second pulse.
    issue(2'd1, 1'b1, 8'd3, got);
    chk("t4_ack", got, 1);
    repeat (11) tick();
    chk("t4_pulse2_hi", phasestep, 1);
    lock = 1'b0;
    tick();
    chk("t4_step_cut", phasestep, 0);
    chk("t4_err", err, 1);
    hi = 0; done_cnt = 0;
    for (int i = 0; i < 20 && pll_rst; i++) begin
      hi++;
      if (done) done_cnt++;
      tick();
    end
    chk("t4_rst_width", hi, 8);
    chk("t4_busy_wait", busy, 1);
    lock = 1'b1;
    tick();
    chk("t4_relock_idle", busy, 0);
    chk("t4_no_done", done_cnt + done, 0);
    chk("t4_err_sticky", err, 1);

    // Request while lock drops in IDLE: lock loss wins, ack only after relock.
    lock = 1'b0; req = 1'b1; sel = 2'd0; dir = 1'b0; steps = 8'd1;
    tick();
    chk("t6_no_ack_drop", ack, 0);
    chk("t6_prst", pll_rst, 1);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      acks += ack;
    end
    chk("t6_no_ack_unlocked", acks, 0);
    lock = 1'b1;
    tick();
    chk("t6_relock_no_ack", ack, 0);
    tick();
    chk("t6_ack", ack, 1);
    chk("t6_err_clr", err, 0);
    sel = 2'd1; steps = 8'd0;
    capture(40);
    chk("t6_trace", ps_vec, exp_ps(1));
    chk("t6_done1", done_cyc, 27);
    chk("t6_ack2", ack_cyc, 28);
    chk("t6_done_cnt", done_cnt, 2);
    chk("t6_sel2", phasesel, 1);

    // Lock held low after PLL reset: timeout, err, and a second reset pulse.
    lock = 1'b0;
    tick();
    chk("t5_prst", pll_rst, 1);
    chk("t5_err_idle", err, 0);
    for (int i = 0; i < 20 && pll_rst; i++) tick();
    lo = 0; err_before = 1'bx;
    for (int i = 0; i < 5000 && !pll_rst; i++) begin
      lo++;
      err_before = err;
      tick();
    end
    chk("t5_wait_len", lo, 4096);
    chk("t5_err_before", err_before, 0);
    chk("t5_err_timeout", err, 1);
    hi = 0;
    for (int i = 0; i < 20 && pll_rst; i++) begin
      hi++;
      tick();
    end
    chk("t5_rst2_width", hi, 8);
    lock = 1'b1;
    tick();
    chk("t5_relock", busy, 0);

    // Reset mid-move truncates the pulse and returns to the reset state.
    issue(2'd0, 1'b0, 8'd2, got);
    repeat (3) tick();
    chk("t7_pulse_hi", phasestep, 1);
    rst = 1'b1;
    tick();
    chk("t7_rst_outs", {phasestep, loadreg, done, err, busy}, 5'b00001);
    rst = 1'b0;
    tick();
    chk("t7_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [1:0] SEL2();
    return 2'd2;
  endfunction

endmodule
